// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline-stage registers.
package pipe_pkg;

  // Decode->execute bundle widths; other stage boundaries override these.
  localparam int DATA_W_DEF = 154;
  localparam int CTRL_W_DEF = 9;

  // Bit positions inside the control field (bit 0 = LSB of the field).
  localparam int CTRL_EXE_CMD_LSB = 0;
  localparam int CTRL_EXE_CMD_W   = 4;
  localparam int CTRL_S_BIT       = 4;
  localparam int CTRL_B_BIT       = 5;
  localparam int CTRL_MEM_W_BIT   = 6;
  localparam int CTRL_MEM_R_BIT   = 7;
  localparam int CTRL_WB_EN_BIT   = 8;

  // EMPTY: nothing held; FULL: main live; SKID: main and skid live.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid
// buffer, registered in_ready and synchronous flush. The control field of
// out_data reads zero whenever the stage is empty, so a consumer that
// ignores out_valid still sees a NOP.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Ones on every non-control bit; ANDing with it clears the control field.
  localparam logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b1}} >> CTRL_W;

  stage_state_e      state;
  stage_state_e      next_state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  logic acc;
  logic con;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic clear_main_ctrl;
  logic clear_skid_ctrl;

  assign acc = in_valid & in_ready;
  assign con = out_valid & out_ready;

  // State register; in_ready is registered from the next state so a
  // downstream stall never reaches upstream combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      // NOTE: flops use non-blocking (<=) so every register samples
      // pre-edge values regardless of block ordering.
      state    <= next_state;
      in_ready <= (next_state != SKID);
    end
  end

  // Next-state decision; flush overrides any accept or consume.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // variable unassigned, which would infer a latch.
    next_state = state;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) next_state = FULL;
        FULL: begin
          if (acc && !con)      next_state = SKID;
          else if (!acc && con) next_state = EMPTY;
        end
        SKID:    if (con) next_state = FULL;
        default: next_state = EMPTY;
      endcase
    end
  end

  // Status outputs and datapath load/clear strobes decoded from state.
  always_comb begin
    out_valid       = (state != EMPTY);
    occupancy       = 2'd0;
    load_main_in    = 1'b0;
    load_main_skid  = 1'b0;
    load_skid       = 1'b0;
    // Entering (or staying in) EMPTY clears main's control field; in
    // EMPTY it is already zero, so re-clearing is harmless.
    clear_main_ctrl = (next_state == EMPTY);
    clear_skid_ctrl = flush;

    case (state)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase

    if (!flush) begin
      case (state)
        EMPTY:   load_main_in   = acc;
        FULL: begin
          load_main_in = acc & con;
          load_skid    = acc & ~con;
        end
        SKID:    load_main_skid = con;
        default: ;
      endcase
    end
  end

  // Main register: drives out_data directly, so no input-to-output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data registers are reset (not left undefined) because
      // out_data must read all-zero after reset, control field included.
      main_q <= '0;
    end else if (clear_main_ctrl) begin
      main_q <= main_q & KEEP_MASK;
    end else if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  // Skid register: catches the word issued upstream during a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_q <= '0;
    end else if (clear_skid_ctrl) begin
      skid_q <= skid_q & KEEP_MASK;
    end else if (load_skid) begin
      skid_q <= in_data;
    end
  end

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a wide (154/9) and a narrow (8/1) instance,
// each compared every cycle against a two-slot FIFO model, plus directed
// vectors with literal expectations.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int WW = 154;
  localparam int NW = 8;
  localparam logic [WW-1:0] W_KEEP = {{9{1'b0}}, {145{1'b1}}};
  localparam logic [WW-1:0] N_KEEP = {{146{1'b0}}, 8'h7F};

  logic clk = 1'b0;
  logic rst;

  logic          w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [WW-1:0] w_in_data, w_out_data;
  logic [1:0]    w_occupancy;

  logic          n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [NW-1:0] n_in_data, n_out_data;
  logic [1:0]    n_occupancy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(WW), .CTRL_W(9)) dut_w (
    .clk(clk), .rst(rst), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .occupancy(w_occupancy)
  );

  pipe_stage_reg #(.DATA_W(NW), .CTRL_W(1)) dut_n (
    .clk(clk), .rst(rst), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .occupancy(n_occupancy)
  );

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [WW-1:0] act,
                           input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: FIFO of at most two words --------
  // Index 0 = wide instance, 1 = narrow instance (zero-extended).
  logic [WW-1:0] m_slot [2][2];
  logic [WW-1:0] m_last [2];
  int            m_cnt  [2];
  bit            m_rdy  [2];

  task automatic model_reset(input int k);
    m_cnt[k]  = 0;
    m_last[k] = '0;
    m_rdy[k]  = 1'b1;
  endtask

  task automatic model_step(input int k, input logic fl, input logic iv,
                            input logic [WW-1:0] d, input logic ordy,
                            input logic [WW-1:0] keep);
    bit acc, con;
    if (fl) begin
      if (m_cnt[k] > 0) m_last[k] = m_slot[k][0];
      m_cnt[k] = 0;
    end else begin
      acc = iv && m_rdy[k];
      con = (m_cnt[k] > 0) && ordy;
      if (con) begin
        m_last[k]    = m_slot[k][0];
        m_slot[k][0] = m_slot[k][1];
        m_cnt[k]     = m_cnt[k] - 1;
      end
      if (acc) begin
        m_slot[k][m_cnt[k]] = d;
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
    if (m_cnt[k] > 0) m_last[k] = m_slot[k][0];
    else              m_last[k] = m_last[k] & keep;
    m_rdy[k] = (m_cnt[k] < 2);
  endtask

  // Compare process: advance the model on every edge, check 1 time unit later.
  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset(0);
        model_reset(1);
      end else begin
        model_step(0, w_flush, w_in_valid, w_in_data, w_out_ready, W_KEEP);
        model_step(1, n_flush, n_in_valid, {146'b0, n_in_data}, n_out_ready, N_KEEP);
      end
      #1;
      check_int("w_out_valid", int'(w_out_valid), int'(m_cnt[0] > 0));
      check_int("w_occupancy", int'(w_occupancy), m_cnt[0]);
      check_int("w_in_ready",  int'(w_in_ready),  int'(m_rdy[0]));
      check_vec("w_out_data",  w_out_data, (m_cnt[0] > 0) ? m_slot[0][0] : m_last[0]);
      check_int("n_out_valid", int'(n_out_valid), int'(m_cnt[1] > 0));
      check_int("n_occupancy", int'(n_occupancy), m_cnt[1]);
      check_int("n_in_ready",  int'(n_in_ready),  int'(m_rdy[1]));
      check_vec("n_out_data",  {146'b0, n_out_data},
                (m_cnt[1] > 0) ? m_slot[1][0] : m_last[1]);
    end
  end

  // ---------------- narrow instance: random traffic all run long --------
  int n_seq = 1;
  bit n_rdy_seen = 1'b1;
  initial begin
    n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      // A valid word was handshaken (or dropped by flush) at this edge.
      if (n_in_valid && (n_rdy_seen || n_flush)) n_seq++;
      if (!n_in_valid || n_rdy_seen || n_flush) begin
        n_in_valid = ($urandom_range(0, 3) != 0);
        n_in_data  = n_seq[7:0];
      end
      n_out_ready = ($urandom_range(0, 3) != 0);
      n_flush     = ($urandom_range(0, 31) == 0);
      n_rdy_seen  = n_in_ready;
    end
  end

  // ---------------- wide instance: directed vectors ---------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_w(input logic fl, input logic iv,
                         input logic [WW-1:0] d, input logic ordy);
    w_flush     = fl;
    w_in_valid  = iv;
    w_in_data   = d;
    w_out_ready = ordy;
  endtask

  logic [WW-1:0] c1, c2, c3, dr_word;
  logic [8:0]    dr_ctrl;
  logic [144:0]  dr_payload;
  bit            w_rdy_seen;

  initial begin
    rst = 1'b1;
    drive_w(1'b0, 1'b0, '0, 1'b0);
    #1 rst = 1'b0;
    #11;
    check_int("reset in_ready", int'(w_in_ready), 1);
    check_int("reset out_valid", int'(w_out_valid), 0);
    check_int("reset occupancy", int'(w_occupancy), 0);
    check_vec("reset out_data", w_out_data, '0);
    @(negedge clk) rst = 1'b1;
    tick();

    // Reset mid-SKID.
    drive_w(1'b0, 1'b1, 154'hA, 1'b0); tick();
    drive_w(1'b0, 1'b1, 154'hB, 1'b0); tick();
    drive_w(1'b0, 1'b0, '0, 1'b0);
    check_int("skid occupancy", int'(w_occupancy), 2);
    check_int("skid in_ready", int'(w_in_ready), 0);
    check_vec("skid out_data", w_out_data, 154'hA);
    #2 rst = 1'b0;
    #1;
    check_int("async rst occupancy", int'(w_occupancy), 0);
    check_int("async rst in_ready", int'(w_in_ready), 1);
    check_int("async rst out_valid", int'(w_out_valid), 0);
    check_vec("async rst out_data", w_out_data, '0);
    @(negedge clk) rst = 1'b1;
    tick();

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive_w(1'b0, 1'b1, 154'(i), 1'b1);
      tick();
      check_vec("stream out_data", w_out_data, 154'(i));
      check_int("stream in_ready", int'(w_in_ready), 1);
    end
    drive_w(1'b0, 1'b0, '0, 1'b1); tick();
    check_int("stream drained", int'(w_out_valid), 0);

    // Stall: 0x11, 0x22, 0x33 with out_ready low from the second cycle.
    drive_w(1'b0, 1'b1, 154'h11, 1'b1); tick();
    check_vec("stall first", w_out_data, 154'h11);
    drive_w(1'b0, 1'b1, 154'h22, 1'b0); tick();
    check_int("stall in_ready low", int'(w_in_ready), 0);
    check_int("stall occupancy", int'(w_occupancy), 2);
    drive_w(1'b0, 1'b1, 154'h33, 1'b0); tick();
    check_vec("stall main held", w_out_data, 154'h11);
    check_int("stall still full", int'(w_occupancy), 2);
    drive_w(1'b0, 1'b1, 154'h33, 1'b1); tick();
    check_vec("stall second out", w_out_data, 154'h22);
    check_int("stall in_ready back", int'(w_in_ready), 1);
    drive_w(1'b0, 1'b1, 154'h33, 1'b1); tick();
    check_vec("stall third out", w_out_data, 154'h33);
    drive_w(1'b0, 1'b0, '0, 1'b1); tick();
    check_int("stall drained", int'(w_occupancy), 0);

    // Flush in SKID with a word presented in the same cycle.
    c1 = {9'h155, 145'h44};
    c2 = {9'h0AA, 145'h55};
    c3 = {9'h1FF, 145'h66};
    drive_w(1'b0, 1'b1, c1, 1'b0); tick();
    drive_w(1'b0, 1'b1, c2, 1'b0); tick();
    drive_w(1'b1, 1'b1, c3, 1'b1); tick();
    check_int("flush skid occupancy", int'(w_occupancy), 0);
    check_int("flush skid out_valid", int'(w_out_valid), 0);
    check_int("flush skid in_ready", int'(w_in_ready), 1);
    check_vec("flush skid out_data", w_out_data, {9'h0, 145'h44});
    drive_w(1'b0, 1'b0, '0, 1'b1); tick();
    check_int("flush skid no ghost", int'(w_occupancy), 0);

    // Flush in FULL while accepting and consuming: the new word is dropped.
    drive_w(1'b0, 1'b1, c2, 1'b0); tick();
    drive_w(1'b1, 1'b1, c3, 1'b1); tick();
    check_int("flush full occupancy", int'(w_occupancy), 0);
    check_vec("flush full out_data", w_out_data, {9'h0, 145'h55});
    drive_w(1'b0, 1'b0, '0, 1'b1); tick();
    check_int("flush full no ghost", int'(w_out_valid), 0);

    // Drain: all control bits set, payload must survive the clear.
    dr_ctrl = '0;
    dr_ctrl[CTRL_WB_EN_BIT] = 1'b1;
    dr_ctrl[CTRL_MEM_R_BIT] = 1'b1;
    dr_ctrl[CTRL_MEM_W_BIT] = 1'b1;
    dr_ctrl[CTRL_B_BIT]     = 1'b1;
    dr_ctrl[CTRL_S_BIT]     = 1'b1;
    dr_ctrl[CTRL_EXE_CMD_LSB +: CTRL_EXE_CMD_W] = '1;
    dr_payload = 145'h0123_4567_89AB_CDEF;
    dr_word = {dr_ctrl, dr_payload};
    drive_w(1'b0, 1'b1, dr_word, 1'b1); tick();
    check_vec("drain live word", w_out_data, {9'h1FF, 145'h0123_4567_89AB_CDEF});
    drive_w(1'b0, 1'b0, '0, 1'b1); tick();
    check_int("drain out_valid", int'(w_out_valid), 0);
    check_vec("drain masked", w_out_data, {9'h000, 145'h0123_4567_89AB_CDEF});

    // Random traffic with a well-behaved upstream (word held until taken).
    w_rdy_seen = w_in_ready;
    drive_w(1'b0, 1'b0, '0, 1'b0);
    for (int c = 0; c < 400; c++) begin
      if (!w_in_valid || w_rdy_seen || w_flush) begin
        w_in_valid = ($urandom_range(0, 2) != 0);
        w_in_data  = {26'($urandom), $urandom, $urandom, $urandom, $urandom};
      end
      w_out_ready = ($urandom_range(0, 2) != 0);
      w_flush     = ($urandom_range(0, 39) == 0);
      w_rdy_seen  = w_in_ready;
      tick();
    end

    drive_w(1'b0, 1'b0, '0, 1'b1);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
